wb_stage: RTL
=============

# wb_stage

Writeback stage of the ARM pipeline, sitting between the memory stage and the register-file write port. It registers each instruction leaving the memory stage and selects the ALU result or the load data. For loads it waits on a multi-cycle data-memory response. It then drives a single-cycle write strobe with destination and result into the register file.

## Interface
- DATA_W, 32, datapath width
- REG_ADDR_W, 4, register index width (16 registers)

- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- VALID_IN  in  1  memory stage presents an instruction
- WB_EN_IN  in  1  instruction writes a register
- MEM_R_EN_IN  in  1  instruction is a load
- DEST_IN  in  REG_ADDR_W  destination register
- ALU_RESULT_IN  in  DATA_W  ALU result / address
- MEM_RDATA  in  DATA_W  data-memory read data
- MEM_RVALID  in  1  MEM_RDATA valid this cycle
- READY  out  1  stage accepts VALID_IN this cycle
- WB_EN  out  1  register-file write strobe
- DEST_WB  out  REG_ADDR_W  write address
- RESULT_WB  out  DATA_W  write data
- RETIRED_CNT  out  32  retired-instruction count (only with WB_RETIRE_CNT_EN)

## Operation
- FSM states: IDLE, WAIT_MEM, WRITE.
- READY = 1 in IDLE and WRITE, 0 in WAIT_MEM. READY is combinational from state only.
- Acceptance is VALID_IN & READY at a rising edge. On acceptance the stage captures WB_EN_IN and DEST_IN.
- Accepted non-load (MEM_R_EN_IN=0): capture ALU_RESULT_IN and go to WRITE.
- Accepted load with MEM_RVALID=1 in the same cycle: capture MEM_RDATA and go to WRITE.
- Accepted load with MEM_RVALID=0: go to WAIT_MEM.
- WAIT_MEM: hold until MEM_RVALID=1, then capture MEM_RDATA and go to WRITE.
- WRITE:
  - WB_EN = captured write enable, for exactly this cycle.
  - A new acceptance in this cycle follows the IDLE rules. Otherwise go to IDLE.
- WB_EN is 0 in IDLE and WAIT_MEM.
- DEST_WB and RESULT_WB are registered. They hold their last values outside WRITE.
- An instruction with WB_EN_IN=0 (store, CMP/TST) still passes through WRITE and retires, but WB_EN stays 0.
- Upstream must hold VALID_IN and its data stable while READY=0. VALID_IN while READY=0 is ignored.
- MEM_RVALID outside WAIT_MEM, and outside the acceptance cycle of a load, is ignored.
- Reset in any state: next state IDLE, and any pending load is dropped.
- Reset values: WB_EN=0, DEST_WB=0, RESULT_WB=0, READY=1, RETIRED_CNT=0.

## Timing
- Non-load, or load with same-cycle RVALID: accepted at edge N → WB_EN=1 during cycle N+1. The register file commits on the falling edge of cycle N+1.
- Load, RVALID first sampled high at edge M (M>N) → WB_EN=1 during cycle M+1. READY=0 during cycles N+1..M.
- Throughput: one instruction per cycle for back-to-back non-loads and zero-wait loads.
- Nothing passes combinationally from inputs to WB_EN, DEST_WB or RESULT_WB.

## Configuration
- WB_RETIRE_CNT_EN defined:
  - RETIRED_CNT exists.
  - It increments by 1 on every cycle spent in WRITE, whether or not the write is enabled.
  - It wraps from 0xFFFFFFFF to 0 and is cleared by rst.
- WB_RETIRE_CNT_EN undefined: the port and the counter logic are absent. All other behaviour is identical.

## Structure
- Shared package holds:
  - wb_state_t: IDLE=2'd0, WAIT_MEM=2'd1, WRITE=2'd2
  - DATA_W and REG_ADDR_W constants, shared with the register file and the memory stage
- One sub-module, wb_retire_counter (clk, rst, inc, count). It is instantiated only under WB_RETIRE_CNT_EN.

## Test plan
- ALU op: VALID_IN=1, WB_EN_IN=1, MEM_R_EN_IN=0, DEST_IN=3, ALU_RESULT_IN=0x00001234 → next cycle WB_EN=1, DEST_WB=3, RESULT_WB=0x00001234. The cycle after, WB_EN=0.
- Load, DEST_IN=5, MEM_RVALID asserted 3 cycles after acceptance with MEM_RDATA=0xDEADBEEF → READY=0 for 3 cycles. Then WB_EN=1 for one cycle with DEST_WB=5, RESULT_WB=0xDEADBEEF.
- Four back-to-back ALU ops, DEST 1..4, results 0x10..0x40 → WB_EN high for 4 consecutive cycles in order. READY never drops.
- Store (WB_EN_IN=0, MEM_R_EN_IN=0) → WB_EN stays 0. RETIRED_CNT increments by 1 (macro on).
- Reset asserted in WAIT_MEM, then MEM_RVALID=1 with 0x55 → no WB_EN pulse, READY=1, outputs at reset values.
- Load accepted with same-cycle MEM_RVALID=1, MEM_RDATA=0xCAFE0001, DEST_IN=7 → WB_EN=1 on the next cycle, identical to ALU latency.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared writeback-stage types and datapath widths, also used by the register
// file and the memory stage.
package wb_stage_pkg;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } wb_state_t;
endpackage

// File: rtl/wb_retire_counter.sv
// Free-running retired-instruction counter; wraps silently at 2^32.
module wb_retire_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] count
);
  always_ff @(posedge clk) begin
    if (rst)      count <= '0;
    else if (inc) count <= count + 32'd1;
  end
endmodule

// File: rtl/wb_stage.sv
// Writeback stage: registers memory-stage results, waits on load data, and
// pulses the register-file write strobe. Optional macro WB_RETIRE_CNT_EN adds RETIRED_CNT.
module wb_stage #(
  parameter int DATA_W     = wb_stage_pkg::DATA_W,
  parameter int REG_ADDR_W = wb_stage_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  VALID_IN,
  input  logic                  WB_EN_IN,
  input  logic                  MEM_R_EN_IN,
  input  logic [REG_ADDR_W-1:0] DEST_IN,
  input  logic [DATA_W-1:0]     ALU_RESULT_IN,
  input  logic [DATA_W-1:0]     MEM_RDATA,
  input  logic                  MEM_RVALID,
  output logic                  READY,
  output logic                  WB_EN,
  output logic [REG_ADDR_W-1:0] DEST_WB,
  output logic [DATA_W-1:0]     RESULT_WB
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]           RETIRED_CNT
`endif
);
  import wb_stage_pkg::*;

  wb_state_t             state_q, state_d;
  logic                  accept;
  logic                  pend_wb_en;
  logic [REG_ADDR_W-1:0] pend_dest;
  logic                  wb_en_q;
  logic                  upd_out;
  logic                  nxt_wb_en;
  logic [REG_ADDR_W-1:0] nxt_dest;
  logic [DATA_W-1:0]     nxt_result;

  assign READY  = (state_q != WAIT_MEM);
  assign accept = VALID_IN & READY;
  assign WB_EN  = (state_q == WRITE) & wb_en_q;

  always_comb begin
    state_d    = state_q;
    upd_out    = 1'b0;
    nxt_wb_en  = WB_EN_IN;
    nxt_dest   = DEST_IN;
    nxt_result = ALU_RESULT_IN;
    case (state_q)
      IDLE, WRITE: begin
        state_d = IDLE;
        if (accept) begin
          if (!MEM_R_EN_IN) begin
            state_d = WRITE;
            upd_out = 1'b1;
          end else if (MEM_RVALID) begin
            state_d    = WRITE;
            upd_out    = 1'b1;
            nxt_result = MEM_RDATA;
          end else begin
            state_d = WAIT_MEM;
          end
        end
      end
      WAIT_MEM: begin
        // Load data arrives later; destination comes from the pending copy.
        nxt_wb_en  = pend_wb_en;
        nxt_dest   = pend_dest;
        nxt_result = MEM_RDATA;
        if (MEM_RVALID) begin
          state_d = WRITE;
          upd_out = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_wb_en <= 1'b0;
      pend_dest  <= '0;
    end else if (accept) begin
      pend_wb_en <= WB_EN_IN;
      pend_dest  <= DEST_IN;
    end
  end

  // Outputs only change on entry to WRITE, so they hold while waiting or idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en_q   <= 1'b0;
      DEST_WB   <= '0;
      RESULT_WB <= '0;
    end else if (upd_out) begin
      wb_en_q   <= nxt_wb_en;
      DEST_WB   <= nxt_dest;
      RESULT_WB <= nxt_result;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  wb_retire_counter u_retire_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (state_q == WRITE),
    .count (RETIRED_CNT)
  );
`endif
endmodule
